// File: rtl/countdown_timer_nbit.sv
// ============================================================================
//  Module   : countdown_timer_nbit
//  Purpose  : Loadable down-counter with start/stop, tc pulse, done flag and
//             optional auto-reload for periodic ticks.
//  Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module countdown_timer_nbit #(
  parameter int CNT_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_value,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 enable,
  input  logic                 auto_reload,
  output logic [CNT_WIDTH-1:0] counter,
  output logic                 tc,
  output logic                 busy,
  output logic                 done
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  localparam logic [CNT_WIDTH-1:0] c_ZERO = '0;
  localparam logic [CNT_WIDTH-1:0] c_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]           state_q,   state_d;
  logic [CNT_WIDTH-1:0] counter_q, counter_d;
  logic [CNT_WIDTH-1:0] reload_q,  reload_d;
  logic                 tc_q,      tc_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= c_IDLE;
      counter_q <= c_ZERO;
      reload_q  <= c_ZERO;
      tc_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      reload_q  <= reload_d;
      tc_q      <= tc_d;
    end
  end

  // Priority: load > stop > start > counting; tc is a single-cycle pulse.
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    reload_d  = reload_q;
    tc_d      = 1'b0;
    if (load) begin
      counter_d = load_value;
      reload_d  = load_value;
      state_d   = c_IDLE;
    end else if (stop) begin
      if (state_q == c_RUN) begin
        state_d = c_IDLE;
      end
    end else begin
      case (state_q)
        c_IDLE: begin
          if (start) begin
            if (counter_q != c_ZERO) begin
              state_d = c_RUN;
            end else begin
              state_d = c_DONE;
              tc_d    = 1'b1;
            end
          end
        end
        c_RUN: begin
          if (enable) begin
            if (counter_q > c_ONE) begin
              counter_d = counter_q - c_ONE;
            end else if (counter_q == c_ONE) begin
              tc_d = 1'b1;
              if (auto_reload) begin
                counter_d = reload_q;
              end else begin
                counter_d = c_ZERO;
                state_d   = c_DONE;
              end
            end
          end
        end
        c_DONE: begin
          if (start) begin
            if (reload_q != c_ZERO) begin
              counter_d = reload_q;
              state_d   = c_RUN;
            end else begin
              tc_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = c_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    counter = counter_q;
    tc      = tc_q;
    busy    = (state_q == c_RUN);
    done    = (state_q == c_DONE);
  end

endmodule

`default_nettype wire

// File: tb/tb_countdown_timer_nbit.sv
// ============================================================================
//  Module   : tb_countdown_timer_nbit
//  Purpose  : Table-driven directed bench for countdown_timer_nbit (width 3).
//  Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_countdown_timer_nbit;

  logic       clk;
  logic       reset_n;
  logic       load;
  logic [2:0] load_value;
  logic       start;
  logic       stop;
  logic       enable;
  logic       auto_reload;
  logic [2:0] counter;
  logic       tc;
  logic       busy;
  logic       done;

  int nvec;
  int nerr;

  typedef struct {
    logic       ld;
    logic [2:0] lv;
    logic       st;
    logic       sp;
    logic       en;
    logic       ar;
    logic [2:0] ec;
    logic       etc;
    logic       eb;
    logic       ed;
  } vec_t;

  vec_t tbl[$];

  countdown_timer_nbit #(.CNT_WIDTH(3)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (load),
    .load_value  (load_value),
    .start       (start),
    .stop        (stop),
    .enable      (enable),
    .auto_reload (auto_reload),
    .counter     (counter),
    .tc          (tc),
    .busy        (busy),
    .done        (done)
  );

  always #500 clk = ~clk;

  function automatic vec_t mk(input logic ld, input logic [2:0] lv, input logic st,
                              input logic sp, input logic en, input logic ar,
                              input logic [2:0] ec, input logic etc, input logic eb,
                              input logic ed);
    vec_t v;
    v.ld = ld; v.lv = lv; v.st = st; v.sp = sp; v.en = en; v.ar = ar;
    v.ec = ec; v.etc = etc; v.eb = eb; v.ed = ed;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] act,
                     input logic [7:0] exp);
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s (step %0d): got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int idx, input logic [2:0] ec,
                         input logic etc, input logic eb, input logic ed);
    nvec++;
    chk({tag, ".counter"}, idx, {5'd0, counter}, {5'd0, ec});
    chk({tag, ".tc"},      idx, {7'd0, tc},      {7'd0, etc});
    chk({tag, ".busy"},    idx, {7'd0, busy},    {7'd0, eb});
    chk({tag, ".done"},    idx, {7'd0, done},    {7'd0, ed});
  endtask

  task automatic apply(input vec_t v, input int idx);
    load        = v.ld;
    load_value  = v.lv;
    start       = v.st;
    stop        = v.sp;
    enable      = v.en;
    auto_reload = v.ar;
    @(posedge clk);
    #1;
    chk_all("tbl", idx, v.ec, v.etc, v.eb, v.ed);
  endtask

  initial begin
    clk = 1'b0; reset_n = 1'b0; nvec = 0; nerr = 0;
    load = 0; load_value = 3'd0; start = 0; stop = 0; enable = 0; auto_reload = 0;

    //        ld lv  st sp en ar  cnt tc b d
    // one-shot of 5, then 10 idle cycles in DONE
    tbl.push_back(mk(1, 5, 0, 0, 0, 0,  5, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 0,  5, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0,  4, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0,  3, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0,  2, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0,  1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0,  0, 1, 0, 1));
    for (int i = 0; i < 10; i++) tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
    // restart from DONE reloads the period
    tbl.push_back(mk(0, 0, 1, 0, 1, 0,  5, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0,  4, 0, 1, 0));
    // auto-reload of 3, stop, resume
    tbl.push_back(mk(1, 3, 0, 0, 0, 1,  3, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 1,  3, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1,  2, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1,  1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1,  3, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1,  2, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1,  1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1,  3, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1,  2, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1,  2, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1,  2, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 1,  2, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1,  1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1,  3, 1, 1, 0));
    // pause at 4, then load+start on the same edge
    tbl.push_back(mk(1, 6, 0, 0, 0, 0,  6, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 0,  6, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0,  5, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0,  4, 0, 1, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 4, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0,  3, 0, 1, 0));
    tbl.push_back(mk(1, 7, 1, 0, 1, 0,  7, 0, 0, 0));
    // zero period: start in IDLE and again in DONE each pulse tc
    tbl.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 0,  0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0,  0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 1, 0,  0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0,  0, 0, 0, 1));
    // auto-reload with period 1: tc every enabled cycle
    tbl.push_back(mk(1, 1, 0, 0, 0, 1,  1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 1,  1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1,  1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1,  1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1,  1, 0, 1, 0));
    // setup for async reset while running at counter=2
    tbl.push_back(mk(1, 4, 0, 0, 0, 0,  4, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 0,  4, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0,  3, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0,  2, 0, 1, 0));

    #200;
    chk_all("reset", 0, 3'd0, 1'b0, 1'b0, 1'b0);
    #500;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("post_reset_idle", 0, 3'd0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // asynchronous reset mid-cycle while RUN at counter=2
    #200;
    reset_n = 1'b0;
    #1;
    chk_all("async_reset", 0, 3'd0, 1'b0, 1'b0, 1'b0);
    start  = 1'b1;
    enable = 1'b1;
    @(posedge clk);
    #1;
    chk_all("start_in_reset", 0, 3'd0, 1'b0, 1'b0, 1'b0);
    start = 1'b0;
    #200;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("after_release", 0, 3'd0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire
